// File: rtl/riscv_core.sv
// Shared core definitions: address width, cache line offset helper and the
// refill sequencer state encoding.
package riscv_core;

   localparam int unsigned ADDR_WIDTH = 32;

   // Number of byte-offset bits within a line of line_size 32-bit words.
   function automatic int unsigned line_off_w(input int unsigned line_size);
      return 2 + $clog2(line_size);
   endfunction

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait,
      StFill
   } refill_state_t;

endpackage

// File: rtl/refill_miss_queue.sv
// Circular FIFO of missing line addresses: two push ports (lane 0 first), one
// pop port, and a per-lane match against the currently valid entries.
module refill_miss_queue
   import riscv_core::*;
#(
   parameter int unsigned QDEPTH = 2,
   parameter int unsigned AW     = ADDR_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic [1:0]         push_valid,
   input  logic [1:0][AW-1:0] push_addr,
   input  logic               pop,
   input  logic [1:0][AW-1:0] match_addr,
   output logic [1:0]         match,
   output logic               empty,
   output logic [AW-1:0]      head_addr
);

   localparam int unsigned PW = $clog2(QDEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0] DEPTH = (CW + 1)'(QDEPTH);

   logic [AW-1:0] mem_q [QDEPTH];
   logic [AW-1:0] mem_d [QDEPTH];
   logic [PW-1:0] rd_q, rd_d, wr;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW:0]   space;
   logic          acc0, acc1;

   // Free slots count the entry popped this cycle, so a full queue can still
   // accept one push while popping.
   always_comb begin
      mem_d = mem_q;
      wr    = rd_q + cnt_q[PW-1:0];
      space = DEPTH - {1'b0, cnt_q} + {{CW{1'b0}}, pop};
      acc0  = push_valid[0] && (space != '0);
      acc1  = push_valid[1] && (space > {{CW{1'b0}}, acc0});
      if (acc0) mem_d[wr] = push_addr[0];
      if (acc1) mem_d[acc0 ? wr + PW'(1) : wr] = push_addr[1];
      cnt_d = cnt_q + CW'(acc0) + CW'(acc1) - CW'(pop);
      rd_d  = rd_q + PW'(pop);
      if (flush) begin
         cnt_d = '0;
         rd_d  = rd_q;
      end
   end

   always_comb begin
      match = '0;
      for (int e = 0; e < QDEPTH; e++) begin
         for (int l = 0; l < 2; l++) begin
            if (({1'b0, PW'(e) - rd_q} < cnt_q) && (mem_q[e] == match_addr[l])) begin
               match[l] = 1'b1;
            end
         end
      end
   end

   assign empty = (cnt_q == '0);
   // An empty queue forwards the incoming lane directly so IDLE can pop it at once.
   assign head_addr = !empty ? mem_q[rd_q] : (push_valid[0] ? push_addr[0] : push_addr[1]);

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction cache miss/refill sequencer: queues missing lines, requests them
// one at a time from memory and writes each returned line into the cache.
module icache_refill_ctrl
   import riscv_core::*;
#(
   parameter int unsigned LINE_SIZE = 2,
   parameter int unsigned QDEPTH    = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [1:0]                   miss,
   input  logic [1:0]                   valid_read,
   input  logic [1:0][ADDR_WIDTH-1:0]   miss_addr,
   input  logic                         ext_stall,
   input  logic                         ext_flush,
   output logic                         mem_req_valid,
   input  logic                         mem_req_ready,
   output logic [ADDR_WIDTH-1:0]        mem_req_addr,
   input  logic                         mem_resp_valid,
   input  logic [32*LINE_SIZE-1:0]      mem_resp_data,
   output logic [ADDR_WIDTH-1:0]        fetch_addr,
   output logic                         fetch_addr_valid,
   output logic [32*LINE_SIZE-1:0]      fetched_data,
   output logic                         refill_busy
);

   localparam int unsigned DW  = 32 * LINE_SIZE;
   localparam int unsigned OFF = line_off_w(LINE_SIZE);
   localparam logic [ADDR_WIDTH-1:0] LA_MASK =
      ~((ADDR_WIDTH'(1) << OFF) - ADDR_WIDTH'(1));

   refill_state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0]        cur_addr_q, cur_addr_d;
   logic [DW-1:0]                line_buf_q, line_buf_d;
   logic [1:0][ADDR_WIDTH-1:0]   line_addr;
   logic [1:0]                   ev, inflight_hit, push_valid, q_match;
   logic                         q_empty, pop;
   logic [ADDR_WIDTH-1:0]        q_head;

   always_comb begin
      for (int l = 0; l < 2; l++) begin
         line_addr[l]    = miss_addr[l] & LA_MASK;
         ev[l]           = valid_read[l] & miss[l];
         inflight_hit[l] = (state_q != StIdle) && (line_addr[l] == cur_addr_q);
      end
      push_valid[0] = ev[0] & ~q_match[0] & ~inflight_hit[0];
      push_valid[1] = ev[1] & ~q_match[1] & ~inflight_hit[1] &
                      ~(ev[0] && (line_addr[1] == line_addr[0]));
   end

   assign pop = (state_q == StIdle) && !ext_flush && (!q_empty || (|push_valid));

   refill_miss_queue #(
      .QDEPTH (QDEPTH),
      .AW     (ADDR_WIDTH)
   ) u_queue (
      .clk        (clk),
      .reset      (reset),
      .flush      (ext_flush),
      .push_valid (push_valid),
      .push_addr  (line_addr),
      .pop        (pop),
      .match_addr (line_addr),
      .match      (q_match),
      .empty      (q_empty),
      .head_addr  (q_head)
   );

   always_comb begin
      state_d          = state_q;
      cur_addr_d       = cur_addr_q;
      line_buf_d       = line_buf_q;
      mem_req_valid    = 1'b0;
      mem_req_addr     = '0;
      fetch_addr       = '0;
      fetch_addr_valid = 1'b0;
      fetched_data     = '0;
      unique case (state_q)
         StIdle: begin
            if (pop) begin
               cur_addr_d = q_head;
               state_d    = StReq;
            end
         end
         StReq: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = cur_addr_q;
            if (mem_req_ready) state_d = StWait;
         end
         StWait: begin
            if (mem_resp_valid) begin
               line_buf_d = mem_resp_data;
               state_d    = StFill;
            end
         end
         StFill: begin
            fetch_addr       = cur_addr_q;
            fetch_addr_valid = 1'b1;
            fetched_data     = line_buf_q;
            // The cache ignores writes while stalled, so hold until a clean cycle.
            if (!ext_stall) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign refill_busy = (state_q != StIdle) || !q_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         cur_addr_q <= '0;
         line_buf_q <= '0;
      end else begin
         state_q    <= state_d;
         cur_addr_q <= cur_addr_d;
         line_buf_q <= line_buf_d;
      end
   end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: directed scenarios plus random traffic, all
// checked each cycle against a queue-based behavioural model.
module tb_icache_refill_ctrl;

   localparam int unsigned LS   = 2;
   localparam int unsigned QD   = 2;
   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 32 * LS;
   localparam int unsigned OFFB = 2 + $clog2(LS);

   logic                 clk = 1'b0;
   logic                 reset;
   logic [1:0]           miss, valid_read;
   logic [1:0][AW-1:0]   miss_addr;
   logic                 ext_stall, ext_flush;
   logic                 mem_req_valid, mem_req_ready;
   logic [AW-1:0]        mem_req_addr;
   logic                 mem_resp_valid;
   logic [DW-1:0]        mem_resp_data;
   logic [AW-1:0]        fetch_addr;
   logic                 fetch_addr_valid;
   logic [DW-1:0]        fetched_data;
   logic                 refill_busy;

   icache_refill_ctrl #(
      .LINE_SIZE (LS),
      .QDEPTH    (QD)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .miss             (miss),
      .valid_read       (valid_read),
      .miss_addr        (miss_addr),
      .ext_stall        (ext_stall),
      .ext_flush        (ext_flush),
      .mem_req_valid    (mem_req_valid),
      .mem_req_ready    (mem_req_ready),
      .mem_req_addr     (mem_req_addr),
      .mem_resp_valid   (mem_resp_valid),
      .mem_resp_data    (mem_resp_data),
      .fetch_addr       (fetch_addr),
      .fetch_addr_valid (fetch_addr_valid),
      .fetched_data     (fetched_data),
      .refill_busy      (refill_busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: pending line addresses, plus the line being serviced and its phase
   // (0 nothing, 1 request offered, 2 awaiting data, 3 writing the cache).
   int             m_phase;
   logic [AW-1:0]  m_q[$];
   logic [AW-1:0]  m_cur;
   logic [DW-1:0]  m_line;

   logic [AW-1:0]  reqs[$];
   int             fills, fav_hi;
   logic [DW-1:0]  fill_data;
   logic [AW-1:0]  fill_addr;

   function automatic logic [AW-1:0] la(input logic [AW-1:0] a);
      return (a >> OFFB) << OFFB;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      logic [AW-1:0] cand[$];
      logic [AW-1:0] a, la0;
      bit            ev0, dup, pop;
      int            space;
      if (reset) begin
         m_phase = 0;
         m_q.delete();
         m_cur  = '0;
         m_line = '0;
         return;
      end
      ev0 = valid_read[0] && miss[0];
      la0 = la(miss_addr[0]);
      for (int i = 0; i < 2; i++) begin
         if (valid_read[i] && miss[i]) begin
            a   = la(miss_addr[i]);
            dup = (m_phase != 0 && a == m_cur) || (i == 1 && ev0 && a == la0);
            foreach (m_q[k]) if (m_q[k] == a) dup = 1'b1;
            if (!dup) cand.push_back(a);
         end
      end
      pop = (m_phase == 0) && !ext_flush && (m_q.size() + cand.size() > 0);
      if (ext_flush) begin
         m_q.delete();
      end else begin
         space = int'(QD) - m_q.size() + int'(pop);
         foreach (cand[k]) begin
            if (space > 0) begin
               m_q.push_back(cand[k]);
               space--;
            end
         end
      end
      if (pop) begin
         m_cur   = m_q.pop_front();
         m_phase = 1;
      end else if (m_phase == 1) begin
         if (mem_req_ready) m_phase = 2;
      end else if (m_phase == 2) begin
         if (mem_resp_valid) begin
            m_line  = mem_resp_data;
            m_phase = 3;
         end
      end else if (m_phase == 3 && !ext_stall) begin
         m_phase = 0;
      end
   endtask

   // One clock: log what the coming edge accepts, advance the model, then
   // compare every output after the edge and clear the one-shot inputs.
   task automatic cyc();
      if (mem_req_valid === 1'b1 && mem_req_ready) reqs.push_back(mem_req_addr);
      if (fetch_addr_valid === 1'b1 && !ext_stall) begin
         fills++;
         fill_data = fetched_data;
         fill_addr = fetch_addr;
      end
      model_step();
      @(posedge clk);
      #1;
      chk("mem_req_valid", 64'(mem_req_valid), 64'(m_phase == 1));
      chk("mem_req_addr", 64'(mem_req_addr), 64'(m_phase == 1 ? m_cur : '0));
      chk("fetch_addr_valid", 64'(fetch_addr_valid), 64'(m_phase == 3));
      chk("fetch_addr", 64'(fetch_addr), 64'(m_phase == 3 ? m_cur : '0));
      chk("fetched_data", 64'(fetched_data), 64'(m_phase == 3 ? m_line : '0));
      chk("refill_busy", 64'(refill_busy), 64'(m_phase != 0 || m_q.size() != 0));
      if (fetch_addr_valid === 1'b1) fav_hi++;
      miss       = '0;
      valid_read = '0;
      ext_flush  = 1'b0;
      reset      = 1'b0;
   endtask

   task automatic clear_obs();
      reqs.delete();
      fills  = 0;
      fav_hi = 0;
   endtask

   task automatic lane_miss(input logic [1:0] lanes, input logic [AW-1:0] a0,
                            input logic [AW-1:0] a1);
      valid_read   = lanes;
      miss         = lanes;
      miss_addr[0] = a0;
      miss_addr[1] = a1;
   endtask

   initial begin
      reset          = 1'b1;
      miss           = '0;
      valid_read     = '0;
      miss_addr      = '0;
      ext_stall      = 1'b0;
      ext_flush      = 1'b0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      clear_obs();
      cyc();
      chk("reset_busy", 64'(refill_busy), 64'(0));
      chk("reset_req_valid", 64'(mem_req_valid), 64'(0));

      // Single miss with minimum latency.
      mem_req_ready = 1'b1;
      lane_miss(2'b01, 32'h1004, 32'h0);
      cyc();
      chk("t1_req_addr", 64'(mem_req_addr), 64'h1000);
      cyc();
      mem_resp_valid = 1'b1;
      mem_resp_data  = 64'hAAAA_BBBB_CCCC_DDDD;
      cyc();
      mem_resp_valid = 1'b0;
      chk("t1_busy_n3", 64'(refill_busy), 64'(1));
      cyc();
      chk("t1_busy_n4", 64'(refill_busy), 64'(0));
      repeat (3) cyc();
      chk("t1_nreq", 64'(reqs.size()), 64'(1));
      chk("t1_nfill", 64'(fills), 64'(1));
      chk("t1_fill_data", 64'(fill_data), 64'hAAAA_BBBB_CCCC_DDDD);
      chk("t1_fill_addr", 64'(fill_addr), 64'h1000);

      // Dual miss, same line: one request.
      clear_obs();
      mem_resp_valid = 1'b1;
      mem_resp_data  = 64'h1111_2222_3333_4444;
      lane_miss(2'b11, 32'h2000, 32'h2004);
      repeat (8) cyc();
      chk("t2_nreq", 64'(reqs.size()), 64'(1));
      if (reqs.size() > 0) chk("t2_req0", 64'(reqs[0]), 64'h2000);
      chk("t2_nfill", 64'(fills), 64'(1));

      // Dual miss, different lines: two requests in lane order.
      clear_obs();
      lane_miss(2'b11, 32'h2000, 32'h3000);
      repeat (12) cyc();
      chk("t3_nreq", 64'(reqs.size()), 64'(2));
      if (reqs.size() > 1) begin
         chk("t3_req0", 64'(reqs[0]), 64'h2000);
         chk("t3_req1", 64'(reqs[1]), 64'h3000);
      end
      chk("t3_busy", 64'(refill_busy), 64'(0));

      // Request held while memory is not ready.
      clear_obs();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      lane_miss(2'b01, 32'h4000, 32'h0);
      cyc();
      repeat (5) begin
         chk("t4_hold_valid", 64'(mem_req_valid), 64'(1));
         chk("t4_hold_addr", 64'(mem_req_addr), 64'h4000);
         cyc();
      end
      mem_req_ready = 1'b1;
      cyc();
      mem_resp_valid = 1'b1;
      repeat (6) cyc();
      chk("t4_nreq", 64'(reqs.size()), 64'(1));

      // Stall during FILL: four write cycles, exit on the first clean one.
      lane_miss(2'b01, 32'h5008, 32'h0);
      cyc();
      cyc();
      clear_obs();
      cyc();
      chk("t5_fill_start", 64'(fetch_addr_valid), 64'(1));
      ext_stall = 1'b1;
      repeat (3) cyc();
      ext_stall = 1'b0;
      cyc();
      chk("t5_fav_cycles", 64'(fav_hi), 64'(4));
      chk("t5_nfill", 64'(fills), 64'(1));
      chk("t5_fill_addr", 64'(fill_addr), 64'h5008 & 64'hFFFF_FFF8);

      // Flush with two queued entries while a line is in flight.
      clear_obs();
      mem_resp_valid = 1'b0;
      lane_miss(2'b01, 32'h6000, 32'h0);
      cyc();
      cyc();
      lane_miss(2'b11, 32'h7000, 32'h8000);
      cyc();
      ext_flush = 1'b1;
      cyc();
      chk("t6_busy_inflight", 64'(refill_busy), 64'(1));
      mem_resp_valid = 1'b1;
      repeat (8) cyc();
      chk("t6_nreq", 64'(reqs.size()), 64'(1));
      chk("t6_nfill", 64'(fills), 64'(1));
      chk("t6_busy", 64'(refill_busy), 64'(0));

      // Reset while waiting for data, then a stray response.
      clear_obs();
      mem_resp_valid = 1'b0;
      lane_miss(2'b01, 32'h9000, 32'h0);
      cyc();
      cyc();
      reset = 1'b1;
      cyc();
      chk("t7_busy", 64'(refill_busy), 64'(0));
      chk("t7_req_valid", 64'(mem_req_valid), 64'(0));
      chk("t7_fav", 64'(fetch_addr_valid), 64'(0));
      mem_resp_valid = 1'b1;
      repeat (4) cyc();
      chk("t7_nfill", 64'(fills), 64'(0));
      chk("t7_nreq", 64'(reqs.size()), 64'(1));

      // Random traffic against the model.
      for (int n = 0; n < 600; n++) begin
         valid_read     = 2'($urandom_range(0, 3));
         miss           = 2'($urandom_range(0, 3));
         for (int l = 0; l < 2; l++) begin
            miss_addr[l] = 32'($urandom_range(1, 4)) * 32'h1000 + 32'($urandom_range(0, 7));
         end
         ext_stall      = ($urandom_range(0, 9) < 3);
         ext_flush      = ($urandom_range(0, 19) == 0);
         reset          = ($urandom_range(0, 99) == 0);
         mem_req_ready  = ($urandom_range(0, 1) == 1);
         mem_resp_valid = ($urandom_range(0, 9) < 4);
         mem_resp_data  = {$urandom, $urandom};
         cyc();
      end
      ext_stall      = 1'b0;
      mem_req_ready  = 1'b1;
      mem_resp_valid = 1'b1;
      repeat (20) cyc();
      chk("drain_busy", 64'(refill_busy), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Miss/refill sequencer for `i_cache`. It collects the per-lane `miss` pulses from the cache stage-2 outputs and queues the missing line addresses. It issues one line request at a time to the next memory level, then drives the returned line into the cache's `fetch_addr` / `fetched_data` write port, honouring the cache's `ext_stall` gating. It sits between the fetch frontend, `i_cache` and the L2/memory request interface.

## Interface
- `LINE_SIZE`, default 2: 32-bit words per cache line; must match `i_cache`.
- `QDEPTH`, default 2: miss-queue entries, power of two, ≥2.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `miss` in [2] × 1: per-lane miss from `i_cache`, qualified by `valid_read`.
- `valid_read` in [2] × 1: lane carried a real read this cycle.
- `miss_addr` in [2] × `ADDR_WIDTH`: PC of each lane, aligned with `miss`, supplied by the frontend.
- `ext_stall` in 1: the same stall as the cache's; no fill is counted while it is high.
- `ext_flush` in 1: frontend redirect.
- `mem_req_valid` out 1: line request valid.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_req_addr` out `ADDR_WIDTH`: line-aligned request address.
- `mem_resp_valid` in 1: response line valid, single-cycle pulse.
- `mem_resp_data` in 32·LINE_SIZE: response line, word 0 in the LSBs.
- `fetch_addr` out `ADDR_WIDTH`: to `i_cache.fetch_addr`.
- `fetch_addr_valid` out 1: to `i_cache.fetch_addr_valid`.
- `fetched_data` out 32·LINE_SIZE: to `i_cache.fetched_data`.
- `refill_busy` out 1: a miss is queued or in flight; the frontend holds its PC.

## Operation
- **Line address.** `la(a) = a` with bits [1+$clog2(LINE_SIZE):0] cleared.
- **Capture.** Lane i is a miss event when `valid_read[i] && miss[i]`.
  - Events are enqueued in lane order, lane 0 first.
  - An event is discarded if its `la` equals a queue entry, the in-flight line, or lane 0's `la` in the same cycle.
  - If the queue is full, the event is dropped. This is harmless because the frontend replays the fetch after `refill_busy` falls.
- **FSM states:** IDLE, REQ, WAIT, FILL.
  - IDLE → REQ when the queue is non-empty. Pop the head into `cur_addr`.
  - REQ: `mem_req_valid=1`, `mem_req_addr=cur_addr`. Once asserted it stays asserted until `mem_req_ready`, and the address does not change. On `mem_req_ready` → WAIT.
  - WAIT: on `mem_resp_valid`, register the data into `line_buf` → FILL. `mem_resp_valid` is ignored outside WAIT.
  - FILL: `fetch_addr=cur_addr`, `fetch_addr_valid=1`, `fetched_data=line_buf`. When `ext_stall=0` this cycle → IDLE. Otherwise stay in FILL, because the cache drops writes while stalled.
- **Flush.** `ext_flush` clears the queue, including any events captured in the same cycle. The in-flight request (REQ/WAIT/FILL) still completes and fills, since the line is correct memory content.
- **Busy.** `refill_busy = (state != IDLE) || queue non-empty`.
- **Reset.** State IDLE, queue empty. All outputs are 0: `mem_req_valid`, `mem_req_addr`, `fetch_addr`, `fetch_addr_valid`, `fetched_data`, `refill_busy`.

## Timing
- All outputs are registered, or decoded from the registered state and `cur_addr`/`line_buf`.
- Minimum miss-to-fill sequence, with the miss at cycle N and `ready` plus the response at the earliest possible cycles:
  - N: enqueue.
  - N+1: REQ, accepted.
  - N+2: WAIT, response arrives.
  - N+3: FILL, `fetch_addr_valid` high.
  - N+4: IDLE, so `refill_busy` falls if the queue is empty.
- Back-to-back misses: the next REQ starts the cycle after FILL exits.
- The queue can enqueue up to 2 entries and pop 1 in the same cycle. The full check uses the pre-pop count plus the pop.

## Structure
- **Shared package `riscv_core` / `riscv_core.svh`:** `ADDR_WIDTH` (existing), the line-offset width helper, and the `refill_state_t` enum.
- **Sub-module `refill_miss_queue`:** a QDEPTH circular FIFO with 2 push ports and 1 pop port, plus a CAM-style match output for dedup. The FSM stays in the top module.

## Test plan
- Single miss, lane 0, addr 0x1004, LINE_SIZE 2, `ready` high, response 0xAAAA_BBBB_CCCC_DDDD one cycle later:
  - `mem_req_addr=0x1000`.
  - Exactly one `fetch_addr_valid` pulse with `fetched_data=0xAAAABBBBCCCCDDDD`.
  - `refill_busy` falls at N+4.
- Dual miss on the same line (0x2000, 0x2004) → exactly one request, 0x2000. Dual miss on different lines (0x2000, 0x3000) → requests 0x2000 then 0x3000, in that order.
- `mem_req_ready` low for 5 cycles in REQ → `mem_req_valid` and the address are held stable for all 5 cycles. No extra request after acceptance.
- `ext_stall` high for 3 cycles during FILL → `fetch_addr_valid` is held for 4 cycles and the FSM leaves FILL on the first unstalled cycle.
- `ext_flush` with 2 entries queued and one in WAIT → the in-flight line still fills. No further requests are issued, and `refill_busy` drops after FILL.
- `reset` asserted while in WAIT → the next cycle shows all outputs 0 and state IDLE. A stray `mem_resp_valid` afterwards produces no fill.
